// File: rtl/execute_writeback_if.sv
// -----------------------------------------------------------------------------
// execute_writeback_if
// Bundles the instruction-issue, debug-port and result signals of the
// execute/writeback block. Clock and reset stay outside, as plain module ports.
//
//   master : drives the issue/debug inputs and observes the results
//   slave  : the execute/writeback datapath itself
//
// Signals
//   rs1, rs2     source register indices (sampled on the read_en edge)
//   read_en      operand-read strobe, starts one instruction
//   alu_code     operation code (one edge after read_en)
//   rd           destination index (two edges after read_en)
//   dbg_we       register-file load strobe
//   dbg_waddr    load address
//   dbg_wdata    load data
//   dbg_raddr    inspection address
//   dbg_rdata    combinational read of regfile[dbg_raddr]
//   result       registered ALU result of the instruction in the write stage
//   result_valid one-cycle pulse following a committed (non-NOP) instruction
// -----------------------------------------------------------------------------
interface execute_writeback_if #(parameter int XLEN = 32);
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic            read_en;
   logic [2:0]      alu_code;
   logic [4:0]      rd;
   logic            dbg_we;
   logic [4:0]      dbg_waddr;
   logic [XLEN-1:0] dbg_wdata;
   logic [4:0]      dbg_raddr;
   logic [XLEN-1:0] dbg_rdata;
   logic [XLEN-1:0] result;
   logic            result_valid;

   modport master (
      output rs1, rs2, read_en, alu_code, rd,
      output dbg_we, dbg_waddr, dbg_wdata, dbg_raddr,
      input  dbg_rdata, result, result_valid
   );

   modport slave (
      input  rs1, rs2, read_en, alu_code, rd,
      input  dbg_we, dbg_waddr, dbg_wdata, dbg_raddr,
      output dbg_rdata, result, result_valid
   );
endinterface

// File: rtl/execute_writeback.sv
// -----------------------------------------------------------------------------
// execute_writeback
// Three-stage operand-read / execute / writeback slice with a 32x32 register
// file. An instruction is started by read_en at edge E (operands latched),
// executed at E+1 (ALU result latched) and written back at E+2, where result
// and result_valid also update. No hazard interlock: a consumer must issue at
// least two edges after its producer, which it then sees through the
// write-through path on the operand read.
//
// Ports
//   clk  rising-edge clock
//   rst  synchronous active-high reset (clears registers and pipeline)
//   bus  execute_writeback_if.slave (issue, debug and result signals)
// -----------------------------------------------------------------------------
module execute_writeback #(
   parameter int XLEN = 32
) (
   input  logic                clk,
   input  logic                rst,
   execute_writeback_if.slave  bus
);

   typedef enum logic [2:0] {
      OP_NOP0 = 3'd0,
      OP_ADD  = 3'd1,
      OP_SUB  = 3'd2,
      OP_AND  = 3'd3,
      OP_OR   = 3'd4,
      OP_SLL  = 3'd5,
      OP_SRL  = 3'd6,
      OP_NOP7 = 3'd7
   } aluOp_e;

   logic [XLEN-1:0] regs_q [32];

   logic [XLEN-1:0] opA_q, opA_d;
   logic [XLEN-1:0] opB_q, opB_d;
   logic            v1_q;

   logic [XLEN-1:0] res_q, res_d;
   logic [2:0]      code_q;
   logic            v2_q;

   logic [XLEN-1:0] result_q;
   logic            resultValid_q;

   logic            pipeWrite;
   logic            dbgWrite;

   function automatic logic isNop(input logic [2:0] code);
      return (code == 3'd0) || (code == 3'd7);
   endfunction

   // Write-enable decode; x0 is never written, so its storage stays zero.
   assign pipeWrite = v2_q && !isNop(code_q) && (bus.rd != 5'd0);
   assign dbgWrite  = bus.dbg_we && (bus.dbg_waddr != 5'd0);

   // Operand read with write-through: a write committing on the same edge is
   // forwarded, with the pipeline write taking precedence over the debug port
   // to mirror the register-file write priority.
   always_comb begin
      opA_d = regs_q[bus.rs1];
      opB_d = regs_q[bus.rs2];
      if (dbgWrite && (bus.dbg_waddr == bus.rs1)) opA_d = bus.dbg_wdata;
      if (dbgWrite && (bus.dbg_waddr == bus.rs2)) opB_d = bus.dbg_wdata;
      if (pipeWrite && (bus.rd == bus.rs1))       opA_d = res_q;
      if (pipeWrite && (bus.rd == bus.rs2))       opB_d = res_q;
      if (bus.rs1 == 5'd0)                        opA_d = '0;
      if (bus.rs2 == 5'd0)                        opB_d = '0;
   end

   // ALU for the execute stage; NOP codes produce zero.
   always_comb begin
      res_d = '0;
      case (aluOp_e'(bus.alu_code))
         OP_ADD:  res_d = opA_q + opB_q;
         OP_SUB:  res_d = opA_q - opB_q;
         OP_AND:  res_d = opA_q & opB_q;
         OP_OR:   res_d = opA_q | opB_q;
         OP_SLL:  res_d = opA_q << opB_q[4:0];
         OP_SRL:  res_d = opA_q >> opB_q[4:0];
         default: res_d = '0;
      endcase
   end

   // Register file. The pipeline write is issued last so that it wins when
   // both ports target the same index; different indices both commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         if (dbgWrite)  regs_q[bus.dbg_waddr] <= bus.dbg_wdata;
         if (pipeWrite) regs_q[bus.rd]        <= res_q;
      end
   end

   // Pipeline stages. Operand and result registers hold when their stage is
   // idle; only the valid bits are cleared, which is what discards in-flight
   // work on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         opA_q         <= '0;
         opB_q         <= '0;
         v1_q          <= 1'b0;
         res_q         <= '0;
         code_q        <= 3'd0;
         v2_q          <= 1'b0;
         result_q      <= '0;
         resultValid_q <= 1'b0;
      end else begin
         v1_q <= bus.read_en;
         if (bus.read_en) begin
            opA_q <= opA_d;
            opB_q <= opB_d;
         end

         v2_q <= v1_q;
         if (v1_q) begin
            res_q  <= res_d;
            code_q <= bus.alu_code;
         end

         resultValid_q <= v2_q && !isNop(code_q);
         if (v2_q) begin
            result_q <= res_q;
         end
      end
   end

   // Debug read port; x0 reads as zero by construction.
   assign bus.dbg_rdata    = (bus.dbg_raddr == 5'd0) ? '0 : regs_q[bus.dbg_raddr];
   assign bus.result       = result_q;
   assign bus.result_valid = resultValid_q;

endmodule
